// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : function codes, engine state encoding and MUL/DIV decode helper
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam logic [4:0] FUNC_ADD     = 5'b00000;
    localparam logic [4:0] FUNC_SUB     = 5'b00001;
    localparam logic [4:0] FUNC_MUL     = 5'b00010;
    localparam logic [4:0] FUNC_DIVU    = 5'b00011;
    localparam logic [4:0] FUNC_AND     = 5'b00100;
    localparam logic [4:0] FUNC_OR      = 5'b00101;
    localparam logic [4:0] FUNC_XOR     = 5'b00110;
    localparam logic [4:0] FUNC_SLT     = 5'b01000;
    localparam logic [4:0] FUNC_SLL     = 5'b01001;
    localparam logic [4:0] FUNC_SRL     = 5'b01010;
    localparam logic [4:0] FUNC_SLT_ALT = 5'b01011;
    localparam logic [4:0] FUNC_SLTU    = 5'b01100;
    localparam logic [4:0] FUNC_ADDPC   = 5'b01101;

    localparam logic [1:0] ENG_IDLE = 2'd0;
    localparam logic [1:0] ENG_RUN  = 2'd1;
    localparam logic [1:0] ENG_DONE = 2'd2;

    function automatic logic IS_MULDIV(input logic [4:0] func);
        return (func == FUNC_MUL) || (func == FUNC_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_engine.sv
`default_nettype none
// ============================================================================
// muldiv_seq_engine : iterative shift-add multiplier / restoring divider
// Rev 1.0
// ============================================================================
module muldiv_seq_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             is_div_q, is_div_d;
    logic             valid_q, valid_d;

    // Division: a_q shifts the dividend out of its MSB while quotient bits enter its LSB.
    logic [WIDTH:0]   w_rem_sh;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_sub;

    assign w_rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign w_fits    = (w_rem_sh >= {1'b0, b_q});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - b_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        is_div_d = is_div_q;
        valid_d  = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    is_div_d = is_div;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ENG_RUN;
                end
            end
            ENG_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (is_div_q) begin
                    acc_d = w_fits ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], w_fits};
                end else begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = {a_q[WIDTH-2:0], 1'b0};
                    b_d = {1'b0, b_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ENG_DONE;
                end
            end
            ENG_DONE: begin
                result_d = is_div_q ? a_q : acc_q;
                valid_d  = 1'b1;
                state_d  = ENG_IDLE;
            end
            default: begin
                state_d = ENG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ENG_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            is_div_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            is_div_q <= is_div_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
    assign busy   = (state_q == ENG_RUN);

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// alu_muldiv_unit : single-cycle ALU, branch flag and MUL/DIVU engine front end
// Rev 1.0
// ============================================================================
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       alu_func,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic             alu_start,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_flag,
    output logic             alu_valid,
    output logic             alu_busy
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_is_muldiv;
    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] w_eng_result;

    assign w_shamt     = alu_b[SHW-1:0];
    assign w_lt_s      = ($signed(alu_a) < $signed(alu_b));
    assign w_lt_u      = (alu_a < alu_b);
    assign w_is_muldiv = IS_MULDIV(alu_func);

    always_comb begin
        w_comb = '0;
        case (alu_func)
            FUNC_ADD, FUNC_ADDPC:   w_comb = alu_a + alu_b;
            FUNC_SUB:               w_comb = alu_a - alu_b;
            FUNC_AND:               w_comb = alu_a & alu_b;
            FUNC_OR:                w_comb = alu_a | alu_b;
            FUNC_XOR:               w_comb = alu_a ^ alu_b;
            FUNC_SLT, FUNC_SLT_ALT: w_comb = {{(WIDTH-1){1'b0}}, w_lt_s};
            FUNC_SLTU:              w_comb = {{(WIDTH-1){1'b0}}, w_lt_u};
            FUNC_SLL:               w_comb = alu_a << w_shamt;
            FUNC_SRL:               w_comb = alu_a >> w_shamt;
            default:                w_comb = '0;
        endcase
    end

    // Compare codes branch on the set-less-than bit; everything else branches on equality.
    always_comb begin
        alu_flag = (alu_a == alu_b);
        case (alu_func)
            FUNC_SLT, FUNC_SLT_ALT, FUNC_SLTU: alu_flag = w_comb[0];
            default:                           alu_flag = (alu_a == alu_b);
        endcase
    end

    muldiv_seq_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (alu_start & w_is_muldiv),
        .is_div (alu_func == FUNC_DIVU),
        .a      (alu_a),
        .b      (alu_b),
        .result (w_eng_result),
        .valid  (alu_valid),
        .busy   (alu_busy)
    );

    assign alu_result = w_is_muldiv ? w_eng_result : w_comb;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv_unit : randomized + directed bench against a behavioural model
// Rev 1.0
// ============================================================================
module tb_alu_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   func;
    logic [W-1:0] a, b;
    logic         start;
    logic [W-1:0] res;
    logic         flag, valid, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_func   (func),
        .alu_a      (a),
        .alu_b      (b),
        .alu_start  (start),
        .alu_result (res),
        .alu_flag   (flag),
        .alu_valid  (valid),
        .alu_busy   (busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference semantics of the single-cycle operations
    function automatic logic [W-1:0] ref_comb(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        case (f)
            5'd0, 5'd13: return x + y;
            5'd1:        return x - y;
            5'd4:        return x & y;
            5'd5:        return x | y;
            5'd6:        return x ^ y;
            5'd8, 5'd11: return ($signed(x) < $signed(y)) ? 1 : 0;
            5'd9:        return x << (y % W);
            5'd10:       return x >> (y % W);
            5'd12:       return (x < y) ? 1 : 0;
            default:     return 0;
        endcase
    endfunction

    // Model of the engine as "a job accepted at edge N finishes at edge N+W+1"
    int unsigned  cyc = 0;
    bit           m_pend = 0;
    bit           m_acc;
    bit           m_valid = 0;
    bit           chk_en = 0;
    int unsigned  m_start, m_done;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_job;

    always @(posedge clk) begin
        cyc++;
        m_valid = 0;
        if (rst) begin
            m_pend = 0;
            m_res  = '0;
            chk_en = 1;
        end else begin
            m_acc = !m_pend && start && (func == 5'd2 || func == 5'd3);
            if (m_pend && cyc == m_done) begin
                m_valid = 1;
                m_res   = m_job;
                m_pend  = 0;
            end
            if (m_acc) begin
                m_pend  = 1;
                m_start = cyc;
                m_done  = cyc + W + 1;
                if (func == 5'd2) m_job = a * b;
                else              m_job = (b == 0) ? '1 : a / b;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] e_res;
            logic         e_flag;
            e_res  = (func == 5'd2 || func == 5'd3) ? m_res : ref_comb(func, a, b);
            e_flag = (func == 5'd8 || func == 5'd11 || func == 5'd12) ? e_res[0] : (a == b);
            chk("model_result", res, e_res);
            chk("model_flag", {31'd0, flag}, {31'd0, e_flag});
            chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
            chk("model_busy", {31'd0, busy}, {31'd0, (m_pend && (cyc - m_start) < W)});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits up to 40 cycles for valid; lat counts edges after the start edge
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic launch(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        func  = f;
        a     = x;
        b     = y;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int lat;
        int pulses;
        logic [W-1:0] seen;

        rst = 1'b1; start = 1'b0; func = 5'd2; a = '0; b = '0;
        cycle();
        cycle();
        @(negedge clk);
        chk("reset_result", res, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        cycle();
        rst = 1'b0;

        func = 5'd0; a = 32'd5; b = 32'd7;
        @(negedge clk);
        chk("add_5_7", res, 32'd12);
        chk("add_valid", {31'd0, valid}, 32'd0);
        func = 5'd1;
        @(negedge clk);
        chk("sub_5_7", res, 32'hFFFF_FFFE);

        cycle();
        launch(5'd2, 32'd1234, 32'd5678);
        wait_valid(lat);
        chk("mul_latency", lat, 32'd33);
        chk("mul_result", res, 32'd7006652);
        @(negedge clk);
        chk("mul_valid_drop", {31'd0, valid}, 32'd0);
        chk("mul_result_held", res, 32'd7006652);

        cycle();
        launch(5'd3, 32'd100, 32'd7);
        wait_valid(lat);
        chk("divu_latency", lat, 32'd33);
        chk("divu_result", res, 32'd14);
        cycle();
        launch(5'd3, 32'd100, 32'd0);
        wait_valid(lat);
        chk("div0_latency", lat, 32'd33);
        chk("div0_result", res, 32'hFFFF_FFFF);

        cycle();
        launch(5'd2, 32'd3, 32'd9);
        repeat (9) cycle();
        launch(5'd2, 32'd11, 32'd13);
        pulses = 0; lat = -1; seen = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (lat < 0) begin
                    lat  = 10 + k;
                    seen = res;
                end
            end
        end
        chk("restart_latency", lat, 32'd33);
        chk("restart_result", seen, 32'd27);
        chk("restart_pulses", pulses, 32'd1);

        cycle();
        launch(5'd3, 32'd1000, 32'd3);
        repeat (14) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_result", res, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 32'd0);
        cycle();
        launch(5'd3, 32'd1000, 32'd3);
        wait_valid(lat);
        chk("after_abort_latency", lat, 32'd33);
        chk("after_abort_result", res, 32'd333);

        cycle();
        func = 5'd8; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        chk("slt_result", res, 32'd1);
        chk("slt_flag", {31'd0, flag}, 32'd1);
        func = 5'd12;
        @(negedge clk);
        chk("sltu_result", res, 32'd0);
        chk("sltu_flag", {31'd0, flag}, 32'd0);
        func = 5'd0; a = 32'd42; b = 32'd42;
        @(negedge clk);
        chk("add_eq_flag", {31'd0, flag}, 32'd1);
        func = 5'd9; a = 32'd1; b = 32'd35;
        @(negedge clk);
        chk("sll_low_bits", res, 32'd8);
        func = 5'd31;
        @(negedge clk);
        chk("undefined_code", res, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            cycle();
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 5) == 0);
            r     = $urandom_range(0, 9);
            if (r < 3)      func = 5'd2;
            else if (r < 5) func = 5'd3;
            else            func = 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      b = '0;
            else if (r == 1) b = a;
            else if (r < 5)  b = 32'($urandom_range(1, 300));
            else             b = 32'($urandom);
        end
        cycle();
        rst = 1'b0; start = 1'b0;
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
